// File: rtl/axi4s_to_vid_out_if.sv
// rtl/axi4s_to_vid_out_if.sv - AXI4-Stream video beat bundle (tdata/tvalid/tready/tuser/tlast)
//   master: drives tdata, tvalid, tuser (start of frame), tlast (end of line); samples tready
//   slave : samples tdata, tvalid, tuser, tlast; drives tready
interface axi4s_to_vid_out_if #(
  parameter int DATA_WIDTH = 16
) ();
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tuser;
  logic                  tlast;

  modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);
endinterface

// File: rtl/axi4s_to_vid_out.sv
// rtl/axi4s_to_vid_out.sv - AXI4-Stream video to parallel video with raster timing, FIFO and frame lock
//   aclk, rst (async, active high), aclken (global clock enable)
//   s_axis_video    : slave stream, tuser = start of frame, tlast = end of line
//   vid_data/vid_de/vid_hblank/vid_vblank/vid_hsync/vid_vsync : registered raster outputs
//   locked          : lock FSM is in RUN
//   underflow/sof_error/eol_error : one-cycle error pulses
module axi4s_to_vid_out #(
  parameter int DATA_WIDTH     = 16,
  parameter int H_ACTIVE       = 640,
  parameter int H_FP           = 16,
  parameter int H_SYNC         = 96,
  parameter int H_BP           = 48,
  parameter int V_ACTIVE       = 480,
  parameter int V_FP           = 10,
  parameter int V_SYNC         = 2,
  parameter int V_BP           = 33,
  parameter int FIFO_ADDR_BITS = 5
) (
  input  logic                  aclk,
  input  logic                  rst,
  input  logic                  aclken,
  axi4s_to_vid_out_if.slave     s_axis_video,
  output logic [DATA_WIDTH-1:0] vid_data,
  output logic                  vid_de,
  output logic                  vid_hblank,
  output logic                  vid_vblank,
  output logic                  vid_hsync,
  output logic                  vid_vsync,
  output logic                  locked,
  output logic                  underflow,
  output logic                  sof_error,
  output logic                  eol_error
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int AW      = FIFO_ADDR_BITS;
  localparam int DEPTH   = 1 << AW;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_EOL  = HW'(H_ACTIVE - 1);
  localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {ST_SYNC = 2'd0, ST_WAIT = 2'd1, ST_RUN = 2'd2} state_t;

  state_t state_q, state_d;

  // Raster counters
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic          h_wrap, frame_end, active, at_origin, at_eol;

  always_comb begin
    h_wrap    = (hcnt_q == H_LAST);
    frame_end = h_wrap && (vcnt_q == V_LAST);
    hcnt_d    = h_wrap ? '0 : hcnt_q + 1'b1;
    vcnt_d    = vcnt_q;
    if (h_wrap) vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
    active    = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
    at_origin = (hcnt_q == '0) && (vcnt_q == '0);
    at_eol    = (hcnt_q == H_EOL);
  end

  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else if (aclken) begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  // FWFT FIFO: word = {tuser, tlast, tdata}; pointers carry a wrap bit
  logic [DATA_WIDTH+1:0] mem [DEPTH];
  logic [AW:0]           wr_ptr_q, rd_ptr_q;
  logic                  empty, full, accept, wr_en, pop;
  logic [AW-1:0]         wr_addr;
  logic [DATA_WIDTH+1:0] head;

  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head   = mem[rd_ptr_q[AW-1:0]];
  assign s_axis_video.tready = aclken && !rst && ((state_q == ST_SYNC) || !full);
  assign accept = s_axis_video.tvalid && s_axis_video.tready;
  // SYNC flushes every cycle, so a SOF beat accepted there lands in slot 0
  assign wr_en   = accept && ((state_q != ST_SYNC) || s_axis_video.tuser);
  assign wr_addr = (state_q == ST_SYNC) ? '0 : wr_ptr_q[AW-1:0];

  always_ff @(posedge aclk) begin
    if (wr_en) mem[wr_addr] <= {s_axis_video.tuser, s_axis_video.tlast, s_axis_video.tdata};
  end

  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (aclken) begin
      if (state_q == ST_SYNC) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= wr_en ? (AW+1)'(1) : '0;
      end else begin
        if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  // Lock FSM: state register
  always_ff @(posedge aclk or posedge rst) begin
    if (rst)         state_q <= ST_SYNC;
    else if (aclken) state_q <= state_d;
  end

  logic sof_missing, sof_early;
  assign sof_missing = at_origin && !head[DATA_WIDTH+1];
  assign sof_early   = !at_origin && head[DATA_WIDTH+1];

  // Lock FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SYNC: if (accept && s_axis_video.tuser) state_d = ST_WAIT;
      ST_WAIT: if (frame_end && !empty) state_d = ST_RUN;
      ST_RUN: begin
        if (active) begin
          if (empty || sof_missing) state_d = ST_SYNC;
          else if (sof_early)       state_d = ST_WAIT;
        end
      end
      default: state_d = ST_SYNC;
    endcase
  end

  // Lock FSM: outputs (pop and next values of the registered outputs)
  logic                  uf_d, sof_d, eol_d;
  logic [DATA_WIDTH-1:0] pix_d;
  always_comb begin
    pop   = 1'b0;
    uf_d  = 1'b0;
    sof_d = 1'b0;
    eol_d = 1'b0;
    pix_d = '0;
    if (state_q == ST_RUN && active) begin
      if (empty)                        uf_d  = 1'b1;
      else if (sof_missing || sof_early) sof_d = 1'b1;
      else begin
        pop   = 1'b1;
        pix_d = head[DATA_WIDTH-1:0];
        eol_d = (head[DATA_WIDTH] != at_eol);
      end
    end
  end

  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      vid_data   <= '0;
      vid_de     <= 1'b0;
      vid_hblank <= 1'b0;
      vid_vblank <= 1'b0;
      vid_hsync  <= 1'b0;
      vid_vsync  <= 1'b0;
      locked     <= 1'b0;
      underflow  <= 1'b0;
      sof_error  <= 1'b0;
      eol_error  <= 1'b0;
    end else if (aclken) begin
      vid_data   <= pix_d;
      vid_de     <= active;
      vid_hblank <= (hcnt_q >= H_ACT);
      vid_vblank <= (vcnt_q >= V_ACT);
      vid_hsync  <= (hcnt_q >= H_SS) && (hcnt_q < H_SE);
      vid_vsync  <= (vcnt_q >= V_SS) && (vcnt_q < V_SE);
      locked     <= (state_d == ST_RUN);
      underflow  <= uf_d;
      sof_error  <= sof_d;
      eol_error  <= eol_d;
    end
  end
endmodule

// File: tb/tb_axi4s_to_vid_out.sv
// tb/tb_axi4s_to_vid_out.sv - directed self-checking bench for axi4s_to_vid_out
module tb_axi4s_to_vid_out;
  logic        aclk, rst, aclken;
  logic [15:0] vid_data;
  logic        vid_de, vid_hblank, vid_vblank, vid_hsync, vid_vsync;
  logic        locked, underflow, sof_error, eol_error;

  axi4s_to_vid_out_if #(.DATA_WIDTH(16)) s_axis_video ();

  axi4s_to_vid_out #(
    .DATA_WIDTH(16), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .FIFO_ADDR_BITS(4)
  ) dut (
    .aclk(aclk), .rst(rst), .aclken(aclken), .s_axis_video(s_axis_video),
    .vid_data(vid_data), .vid_de(vid_de), .vid_hblank(vid_hblank), .vid_vblank(vid_vblank),
    .vid_hsync(vid_hsync), .vid_vsync(vid_vsync), .locked(locked),
    .underflow(underflow), .sof_error(sof_error), .eol_error(eol_error)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int          total, bad;
  int          ocnt;           // aclken-qualified edges since reset release
  int          sidx, gap_lo, gap_hi;
  logic        rdy_seen;
  logic [17:0] sq[$];          // {tuser, tlast, tdata}

  function automatic logic [15:0] pix(int f, int i);
    return 16'(40960 + f * 256 + i);
  endfunction

  // {de, hblank, vblank, hsync, vsync} for raster position of the oc-th enabled edge
  function automatic logic [4:0] exp_tim(int oc);
    int p, h, v;
    if (oc == 0) return 5'b0;
    p = (oc - 1) % 98; h = p % 14; v = p / 14;
    return {h < 8 && v < 4, h >= 8, v >= 4, h >= 10 && h < 12, v == 5};
  endfunction

  // raster frame F shows stream frame F-1 once locked
  function automatic logic [15:0] exp_norm(int oc);
    int f, p, h, v;
    if (oc == 0) return 16'h0;
    f = (oc - 1) / 98; p = (oc - 1) % 98; h = p % 14; v = p / 14;
    if (f >= 1 && h < 8 && v < 4) return pix(f - 1, v * 8 + h);
    return 16'h0;
  endfunction

  function automatic logic [24:0] obs();
    return {locked, underflow, sof_error, eol_error,
            vid_de, vid_hblank, vid_vblank, vid_hsync, vid_vsync, vid_data};
  endfunction

  task automatic push_frame(int f, int n, int badpos);
    for (int i = 0; i < n; i++) sq.push_back({i == 0, (i % 8 == 7) || (i == badpos), pix(f, i)});
  endtask

  task automatic do_reset();
    s_axis_video.tvalid = 1'b0; s_axis_video.tdata = '0;
    s_axis_video.tuser = 1'b0; s_axis_video.tlast = 1'b0;
    aclken = 1'b1; rst = 1'b1;
    @(posedge aclk); @(negedge aclk);
    rst = 1'b0;
    ocnt = 0; sidx = 0; gap_lo = 0; gap_hi = 0;
    sq.delete();
  endtask

  task automatic cycle(input logic en);
    logic acc;
    if (sidx < sq.size() && !(ocnt >= gap_lo && ocnt < gap_hi)) begin
      s_axis_video.tvalid = 1'b1;
      {s_axis_video.tuser, s_axis_video.tlast, s_axis_video.tdata} = sq[sidx];
    end else begin
      s_axis_video.tvalid = 1'b0; s_axis_video.tdata = '0;
      s_axis_video.tuser = 1'b0; s_axis_video.tlast = 1'b0;
    end
    aclken = en;
    #1;
    acc = s_axis_video.tvalid && s_axis_video.tready;
    rdy_seen = s_axis_video.tready;
    @(posedge aclk);
    if (acc) sidx++;
    if (en) ocnt++;
    @(negedge aclk);
  endtask

  task automatic test_reset();
    logic [25:0] got, exp;
    rst = 1'b1; aclken = 1'b1; #1;
    total++;
    if (obs() !== 25'h0) begin bad++; $display("FAIL reset_outputs got=%h exp=0", obs()); end
    total++;
    if (s_axis_video.tready !== 1'b0) begin bad++; $display("FAIL reset_tready got=%b exp=0", s_axis_video.tready); end
    do_reset();
    for (int c = 0; c < 196; c++) begin
      cycle(1'b1);
      got = {rdy_seen, obs()};
      exp = {1'b1, 4'b0000, exp_tim(ocnt), 16'h0};
      total++;
      if (got !== exp) begin bad++; $display("FAIL idle_raster oc=%0d got=%h exp=%h", ocnt, got, exp); end
    end
  endtask

  task automatic test_continuous();
    logic [24:0] exp;
    do_reset();
    for (int f = 0; f < 3; f++) push_frame(f, 32, -1);
    for (int c = 0; c < 392; c++) begin
      cycle(1'b1);
      exp = {ocnt >= 98, 3'b000, exp_tim(ocnt), exp_norm(ocnt)};
      total++;
      if (obs() !== exp) begin bad++; $display("FAIL continuous oc=%0d got=%h exp=%h", ocnt, obs(), exp); end
    end
  endtask

  task automatic test_underflow();
    logic [24:0] exp;
    logic        lk;
    logic [15:0] d;
    do_reset();
    for (int f = 0; f < 4; f++) push_frame(f, 32, -1);
    gap_lo = 190; gap_hi = 230;
    for (int c = 0; c < 392; c++) begin
      cycle(1'b1);
      lk  = (ocnt >= 98 && ocnt < 225) || ocnt >= 294;
      d   = (ocnt >= 225 && ocnt <= 294) ? 16'h0 : exp_norm(ocnt);
      exp = {lk, ocnt == 225, 2'b00, exp_tim(ocnt), d};
      total++;
      if (obs() !== exp) begin bad++; $display("FAIL underflow oc=%0d got=%h exp=%h", ocnt, obs(), exp); end
    end
  endtask

  task automatic test_early_sof();
    logic [24:0] exp;
    logic        lk;
    logic [15:0] d;
    do_reset();
    push_frame(0, 32, -1); push_frame(1, 24, -1);
    push_frame(2, 32, -1); push_frame(3, 32, -1);
    for (int c = 0; c < 392; c++) begin
      cycle(1'b1);
      lk  = (ocnt >= 98 && ocnt < 239) || ocnt >= 294;
      d   = (ocnt >= 239 && ocnt <= 294) ? 16'h0 : exp_norm(ocnt);
      exp = {lk, 1'b0, ocnt == 239, 1'b0, exp_tim(ocnt), d};
      total++;
      if (obs() !== exp) begin bad++; $display("FAIL early_sof oc=%0d got=%h exp=%h", ocnt, obs(), exp); end
    end
  endtask

  task automatic test_junk_eol();
    logic [24:0] exp;
    do_reset();
    for (int j = 0; j < 5; j++) sq.push_back({2'b00, 16'(20480 + j)});
    push_frame(0, 32, 3); push_frame(1, 32, -1);
    for (int c = 0; c < 294; c++) begin
      cycle(1'b1);
      if (c < 6) begin
        total++;
        if (rdy_seen !== 1'b1) begin bad++; $display("FAIL junk_tready c=%0d got=%b exp=1", c, rdy_seen); end
      end
      exp = {ocnt >= 98, 2'b00, ocnt == 102, exp_tim(ocnt), exp_norm(ocnt)};
      total++;
      if (obs() !== exp) begin bad++; $display("FAIL junk_eol oc=%0d got=%h exp=%h", ocnt, obs(), exp); end
    end
  endtask

  task automatic test_controls();
    logic [24:0] exp;
    logic        en;
    do_reset();
    for (int f = 0; f < 3; f++) push_frame(f, 32, -1);
    for (int c = 0; c < 257; c++) begin
      en = (c % 2 == 0);
      cycle(en);
      if (!en) begin
        total++;
        if (rdy_seen !== 1'b0) begin bad++; $display("FAIL clken_tready c=%0d got=%b exp=0", c, rdy_seen); end
      end
      exp = {ocnt >= 98, 3'b000, exp_tim(ocnt), exp_norm(ocnt)};
      total++;
      if (obs() !== exp) begin bad++; $display("FAIL clken oc=%0d got=%h exp=%h", ocnt, obs(), exp); end
    end
    // mid-line asynchronous reset while outputs carry live pixel data
    #2 rst = 1'b1; #1;
    total++;
    if (obs() !== 25'h0) begin bad++; $display("FAIL async_rst got=%h exp=0", obs()); end
    total++;
    if (s_axis_video.tready !== 1'b0) begin bad++; $display("FAIL async_rst_tready got=%b exp=0", s_axis_video.tready); end
    @(negedge aclk);
    do_reset();
    for (int c = 0; c < 14; c++) begin
      cycle(1'b1);
      exp = {4'b0000, exp_tim(ocnt), 16'h0};
      total++;
      if (obs() !== exp) begin bad++; $display("FAIL post_rst oc=%0d got=%h exp=%h", ocnt, obs(), exp); end
    end
  endtask

  initial begin
    total = 0; bad = 0; ocnt = 0; sidx = 0; gap_lo = 0; gap_hi = 0;
    rst = 1'b1; aclken = 1'b1;
    s_axis_video.tvalid = 1'b0; s_axis_video.tdata = '0;
    s_axis_video.tuser = 1'b0; s_axis_video.tlast = 1'b0;
    @(negedge aclk);
    test_reset();
    test_continuous();
    test_underflow();
    test_early_sof();
    test_junk_eol();
    test_controls();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
